// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file constants and the write-port record used by the writeback arbiter.
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 16;
  localparam int BYTE_W     = 8;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic                  wide;
    logic [BYTE_W-1:0]     data;
    logic [REG_DATA_W-1:0] data_wide;
  } wr_port_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en,
                                                     input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = '0;
    reg_onehot[addr] = en;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_pick.sv
// Round-robin picker: first set mask bit at or after start, wrapping modulo N.
module wb_rr_pick
  import reg_wb_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] start,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum_arr [N];
  logic [PTR_W-1:0] pos_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
      assign sum_arr[gi] = {1'b0, start} + SW'(gi);
      assign pos_arr[gi] = (sum_arr[gi] >= SW'(N)) ? PTR_W'(sum_arr[gi] - SW'(N))
                                                   : sum_arr[gi][PTR_W-1:0];
    end
  endgenerate

  // Walk the scan order backwards so the earliest hit is the last assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[pos_arr[k]]) begin
        found = 1'b1;
        idx   = pos_arr[k];
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin share of the two register-file write ports
// between NUM_REQ requesters, with a registered port stage.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hold_i,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_wide,
  input  logic [REG_DATA_W*NUM_REQ-1:0]    req_data,
  output logic                             wr_a_en,
  output logic [REG_ADDR_W-1:0]            wr_a_addr,
  output logic                             wr_a_wide,
  output logic [BYTE_W-1:0]                wr_a_data,
  output logic [REG_DATA_W-1:0]            wr_a_data_wide,
  output logic                             wr_b_en,
  output logic [REG_ADDR_W-1:0]            wr_b_addr,
  output logic                             wr_b_wide,
  output logic [BYTE_W-1:0]                wr_b_data,
  output logic [REG_DATA_W-1:0]            wr_b_data_wide,
  output logic [NUM_REGS-1:0]              pend_mask
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [REG_ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [REG_DATA_W-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    mask_b;
  logic                  found_a, found_b, win_a, win_b;
  logic [PTR_W-1:0]      idx_a, idx_b;
  logic [REG_ADDR_W-1:0] addr_a;
  logic [PTR_W-1:0]      rr_ptr_reg, rr_ptr_next;
  wr_port_t              port_a_reg, port_a_next;
  wr_port_t              port_b_reg, port_b_next;

  assign addr_a = addr_arr[idx_a];
  assign win_a  = found_a && !hold_i;
  assign win_b  = found_b && !hold_i;

  // R0 writes are acknowledged and dropped without taking a port slot.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
      assign data_arr[gi]  = req_data[gi*REG_DATA_W +: REG_DATA_W];
      assign elig[gi]      = req_valid[gi] && (addr_arr[gi] != '0);
      assign mask_b[gi]    = elig[gi] && (addr_arr[gi] != addr_a);
      assign req_ready[gi] = !hold_i && req_valid[gi] &&
                             ((addr_arr[gi] == '0) ||
                              (win_a && (idx_a == PTR_W'(gi))) ||
                              (win_b && (idx_b == PTR_W'(gi))));
    end
  endgenerate

  wb_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_a (
    .mask  (elig),
    .start (rr_ptr_reg),
    .found (found_a),
    .idx   (idx_a)
  );

  wb_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_b (
    .mask  (mask_b),
    .start (rr_ptr_reg),
    .found (found_b),
    .idx   (idx_b)
  );

  function automatic wr_port_t load_port(input wr_port_t              cur,
                                         input logic                  win,
                                         input logic [REG_ADDR_W-1:0] addr,
                                         input logic                  wide,
                                         input logic [REG_DATA_W-1:0] data);
    load_port      = cur;
    load_port.en   = win;
    load_port.wide = 1'b0;
    if (win) begin
      load_port.addr      = addr;
      load_port.wide      = wide;
      load_port.data      = data[BYTE_W-1:0];
      load_port.data_wide = data;
    end
  endfunction

  assign port_a_next = load_port(port_a_reg, win_a, addr_a, req_wide[idx_a], data_arr[idx_a]);
  assign port_b_next = load_port(port_b_reg, win_b, addr_arr[idx_b], req_wide[idx_b],
                                 data_arr[idx_b]);

  // Pointer moves just past winner A so a conflict loser leads the next scan.
  assign rr_ptr_next = !win_a ? rr_ptr_reg :
                       (idx_a == PTR_W'(NUM_REQ - 1)) ? '0 : idx_a + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_a_reg <= '0;
      port_b_reg <= '0;
      rr_ptr_reg <= '0;
    end else begin
      port_a_reg <= port_a_next;
      port_b_reg <= port_b_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign wr_a_en        = port_a_reg.en;
  assign wr_a_addr      = port_a_reg.addr;
  assign wr_a_wide      = port_a_reg.wide;
  assign wr_a_data      = port_a_reg.data;
  assign wr_a_data_wide = port_a_reg.data_wide;
  assign wr_b_en        = port_b_reg.en;
  assign wr_b_addr      = port_b_reg.addr;
  assign wr_b_wide      = port_b_reg.wide;
  assign wr_b_data      = port_b_reg.data;
  assign wr_b_data_wide = port_b_reg.data_wide;

  assign pend_mask = (reg_onehot(port_a_reg.en, port_a_reg.addr) |
                      reg_onehot(port_b_reg.en, port_b_reg.addr)) &
                     {{(NUM_REGS-1){1'b1}}, 1'b0};

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter (NUM_REQ=3): vector table plus multi-cycle sequences.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_i;
  logic [2:0]  req_valid, req_ready, req_wide;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic        wr_a_en, wr_a_wide, wr_b_en, wr_b_wide;
  logic [3:0]  wr_a_addr, wr_b_addr;
  logic [7:0]  wr_a_data, wr_b_data;
  logic [15:0] wr_a_data_wide, wr_b_data_wide, pend_mask;

  reg_wb_arbiter #(.NUM_REQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wide(req_wide), .req_data(req_data),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_wide(wr_a_wide),
    .wr_a_data(wr_a_data), .wr_a_data_wide(wr_a_data_wide),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_wide(wr_b_wide),
    .wr_b_data(wr_b_data), .wr_b_data_wide(wr_b_data_wide),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        a_en;
    logic [3:0]  a_addr;
    logic        a_wide;
    logic [15:0] a_val;
    logic        b_en;
    logic [3:0]  b_addr;
    logic        b_wide;
    logic [15:0] b_val;
    logic [15:0] pend;
  } stage_exp_t;

  typedef struct {
    string       name;
    logic        hold;
    logic [2:0]  valid;
    logic [11:0] addr;
    logic [2:0]  wide;
    logic [47:0] data;
    logic [2:0]  ready;
    stage_exp_t  exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  stage_exp_t  sb_q[$];
  vec_t        vecs[8];
  logic [2:0]  ready_seen;
  logic [15:0] rf [16];
  int          acc_cnt [3];
  int          last_acc [3];
  logic [3:0]  fadr [3];
  logic [15:0] fdat [3];

  // Register-file model fed only by the DUT write ports.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) rf[r] <= 16'h0;
    end else begin
      if (wr_a_en) rf[wr_a_addr] <= wr_a_wide ? wr_a_data_wide : {rf[wr_a_addr][15:8], wr_a_data};
      if (wr_b_en) rf[wr_b_addr] <= wr_b_wide ? wr_b_data_wide : {rf[wr_b_addr][15:8], wr_b_data};
    end
  end

  function automatic stage_exp_t st(input logic ae, input logic [3:0] aa, input logic aw,
                                    input logic [15:0] av, input logic be, input logic [3:0] ba,
                                    input logic bw, input logic [15:0] bv, input logic [15:0] pend);
    st = '{ae, aa, aw, av, be, ba, bw, bv, pend};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_stage(input string tag);
    stage_exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard actual=empty required=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".a_en"}, 64'(wr_a_en), 64'(e.a_en));
    chk({tag, ".a_wide"}, 64'(wr_a_wide), 64'(e.a_wide));
    if (e.a_en) begin
      chk({tag, ".a_addr"}, 64'(wr_a_addr), 64'(e.a_addr));
      if (e.a_wide) chk({tag, ".a_data_wide"}, 64'(wr_a_data_wide), 64'(e.a_val));
      else          chk({tag, ".a_data"}, 64'(wr_a_data), 64'(e.a_val[7:0]));
    end
    chk({tag, ".b_en"}, 64'(wr_b_en), 64'(e.b_en));
    chk({tag, ".b_wide"}, 64'(wr_b_wide), 64'(e.b_wide));
    if (e.b_en) begin
      chk({tag, ".b_addr"}, 64'(wr_b_addr), 64'(e.b_addr));
      if (e.b_wide) chk({tag, ".b_data_wide"}, 64'(wr_b_data_wide), 64'(e.b_val));
      else          chk({tag, ".b_data"}, 64'(wr_b_data), 64'(e.b_val[7:0]));
    end
    chk({tag, ".pend"}, 64'(pend_mask), 64'(e.pend));
    if (wr_a_en && wr_b_en)
      chk({tag, ".port_addr_distinct"}, 64'(wr_a_addr != wr_b_addr), 64'(1));
  endtask

  // Called at posedge+1; checks ready combinationally, then the port stage after the edge.
  task automatic drive(input string tag, input logic hold, input logic [2:0] v,
                       input logic [11:0] a, input logic [2:0] w, input logic [47:0] d,
                       input logic [2:0] exp_ready, input stage_exp_t e);
    hold_i    = hold;
    req_valid = v;
    req_addr  = a;
    req_wide  = w;
    req_data  = d;
    #1;
    ready_seen = req_ready;
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_stage(tag);
    txn++;
    $display("txn %0d %s ready=%b a_en=%b a_addr=%0d b_en=%b b_addr=%0d pend=%h",
             txn, tag, ready_seen, wr_a_en, wr_a_addr, wr_b_en, wr_b_addr, pend_mask);
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 3'b000, 12'h0, 3'b000, 48'h0, 3'b000, st(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    hold_i    = 1'b0;
    req_valid = 3'b000;
    #1;
    chk("reset.port_a", 64'({wr_a_en, wr_a_addr, wr_a_wide, wr_a_data, wr_a_data_wide}), 64'(0));
    chk("reset.port_b", 64'({wr_b_en, wr_b_addr, wr_b_wide, wr_b_data, wr_b_data_wide}), 64'(0));
    chk("reset.pend", 64'(pend_mask), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; req_valid = '0; req_addr = '0; req_wide = '0; req_data = '0;
    vecs[0] = '{"r0drop", 1'b0, 3'b111, {4'd6, 4'd4, 4'd0}, 3'b000, {16'h0099, 16'h0042, 16'h0000},
                3'b111, st(1, 4, 0, 16'h0042, 1, 6, 0, 16'h0099, 16'h0050)};
    vecs[1] = '{"hold", 1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, 3'b111, {16'h3333, 16'h2222, 16'h1111},
                3'b000, st(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{"idle", 1'b0, 3'b000, 12'h0, 3'b000, 48'h0, 3'b000, st(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{"single", 1'b0, 3'b100, {4'd15, 4'd0, 4'd0}, 3'b100, {16'hF00D, 16'h0, 16'h0},
                3'b100, st(1, 15, 1, 16'hF00D, 0, 0, 0, 0, 16'h8000)};
    vecs[4] = '{"narrow", 1'b0, 3'b001, {4'd0, 4'd0, 4'd7}, 3'b000, {16'h0, 16'h0, 16'h1234},
                3'b001, st(1, 7, 0, 16'h0034, 0, 0, 0, 0, 16'h0080)};
    vecs[5] = '{"same3", 1'b0, 3'b111, {4'd9, 4'd9, 4'd9}, 3'b111, {16'h0003, 16'h0002, 16'h0001},
                3'b001, st(1, 9, 1, 16'h0001, 0, 0, 0, 0, 16'h0200)};
    vecs[6] = '{"mix", 1'b0, 3'b111, {4'd10, 4'd9, 4'd9}, 3'b111, {16'h000C, 16'h000B, 16'h000A},
                3'b101, st(1, 9, 1, 16'h000A, 1, 10, 1, 16'h000C, 16'h0600)};
    vecs[7] = '{"all_r0", 1'b0, 3'b111, 12'h0, 3'b111, {16'h7, 16'h6, 16'h5},
                3'b111, st(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    @(posedge clk);
    #1;

    // Fill: two accepted in cycle 0, the third on port A next.
    do_reset();
    drive("fill0", 0, 3'b111, {4'd3, 4'd2, 4'd1}, 3'b111, {16'h3333, 16'h2222, 16'h1111},
          3'b011, st(1, 1, 1, 16'h1111, 1, 2, 1, 16'h2222, 16'h0006));
    drive("fill1", 0, 3'b100, {4'd3, 4'd2, 4'd1}, 3'b111, {16'h3333, 16'h2222, 16'h1111},
          3'b100, st(1, 3, 1, 16'h3333, 0, 0, 0, 0, 16'h0008));
    idle("fill2");

    // Same-register conflict serialised in round-robin order on port A.
    do_reset();
    drive("conf0", 0, 3'b011, {4'd0, 4'd5, 4'd5}, 3'b011, {16'h0, 16'hBBBB, 16'hAAAA},
          3'b001, st(1, 5, 1, 16'hAAAA, 0, 0, 0, 0, 16'h0020));
    drive("conf1", 0, 3'b010, {4'd0, 4'd5, 4'd5}, 3'b011, {16'h0, 16'hBBBB, 16'hAAAA},
          3'b010, st(1, 5, 1, 16'hBBBB, 0, 0, 0, 0, 16'h0020));
    idle("conf2");
    chk("conf.rf_r5", 64'(rf[5]), 64'(16'hBBBB));

    // R0 drop with narrow writes reaching the register file.
    do_reset();
    drive("r0seq0", vecs[0].hold, vecs[0].valid, vecs[0].addr, vecs[0].wide, vecs[0].data,
          vecs[0].ready, vecs[0].exp);
    idle("r0seq1");
    chk("r0.rf_r4", 64'(rf[4]), 64'(16'h0042));
    chk("r0.rf_r6", 64'(rf[6]), 64'(16'h0099));

    // Hold for three cycles keeps rr_ptr at 1; arbitration resumes at requester 1.
    do_reset();
    drive("hold0", 0, 3'b111, {4'd3, 4'd2, 4'd1}, 3'b111, {16'h3333, 16'h2222, 16'h1111},
          3'b011, st(1, 1, 1, 16'h1111, 1, 2, 1, 16'h2222, 16'h0006));
    for (int h = 1; h <= 3; h++)
      drive($sformatf("hold%0d", h), 1, 3'b111, {4'd3, 4'd9, 4'd8}, 3'b111,
            {16'h3333, 16'h9999, 16'h8888}, 3'b000, st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive("hold4", 0, 3'b111, {4'd3, 4'd9, 4'd8}, 3'b111, {16'h3333, 16'h9999, 16'h8888},
          3'b110, st(1, 9, 1, 16'h9999, 1, 3, 1, 16'h3333, 16'h0208));
    drive("hold5", 0, 3'b001, {4'd3, 4'd9, 4'd8}, 3'b111, {16'h3333, 16'h9999, 16'h8888},
          3'b001, st(1, 8, 1, 16'h8888, 0, 0, 0, 0, 16'h0100));

    // Single-cycle vectors, each from a fresh reset (rr_ptr=0).
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].name, vecs[i].hold, vecs[i].valid, vecs[i].addr, vecs[i].wide,
            vecs[i].data, vecs[i].ready, vecs[i].exp);
    end

    // Fairness: three requesters always valid to disjoint register ranges.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      acc_cnt[i]  = 0;
      last_acc[i] = -1;
    end
    for (int k = 0; k < 30; k++) begin
      int ai, bi;
      logic [2:0] er;
      ai = k % 3;
      bi = (k % 3 == 2) ? 0 : ai + 1;
      er = (k % 3 == 0) ? 3'b011 : (k % 3 == 1) ? 3'b110 : 3'b101;
      for (int i = 0; i < 3; i++) begin
        fadr[i] = 4'(1 + 5 * i + (acc_cnt[i] % 5));
        fdat[i] = {4'(i + 1), 12'(acc_cnt[i])};
      end
      drive($sformatf("fair%0d", k), 0, 3'b111, {fadr[2], fadr[1], fadr[0]}, 3'b111,
            {fdat[2], fdat[1], fdat[0]}, er,
            st(1, fadr[ai], 1, fdat[ai], 1, fadr[bi], 1, fdat[bi],
               (16'h1 << fadr[ai]) | (16'h1 << fadr[bi])));
      for (int i = 0; i < 3; i++) begin
        if (ready_seen[i]) begin
          if (last_acc[i] >= 0)
            chk($sformatf("fair.gap_req%0d", i), 64'(k - last_acc[i] <= 2), 64'(1));
          last_acc[i] = k;
        end
      end
      acc_cnt[ai]++;
      acc_cnt[bi]++;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("fair.recent_req%0d", i), 64'(29 - last_acc[i] <= 1), 64'(1));
    idle("fair_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
